// File: rtl/byte_serial_adder.sv
// byte_serial_adder: LSB-first byte-serial multi-byte adder with carry register and valid/ready result port
module byte_ripple_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[8];
endmodule

module byte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_a,
  input  logic [7:0]            in_b,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf
);
  localparam int KW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic                carry_q, carry_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [8*NBYTES-1:0] sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          s;
  logic                c, ci, accept, last;
  assign ci     = (k_q == '0) ? in_cin : carry_q;
  assign accept = (state_q == ACCUM) && in_valid && in_ready_q;
  assign last   = k_q == KW'(NBYTES - 1);
  byte_ripple_adder u_add (.a(in_a), .b(in_b), .cin(ci), .sum(s), .cout(c));
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (state_q == IDLE) begin
      state_d    = ACCUM;
      in_ready_d = 1'b1;
    end else if (clr || (state_q == DONE && out_ready)) begin
      state_d     = ACCUM;
      k_d         = '0;
      carry_d     = 1'b0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else if (accept) begin
      sum_d[{k_q, 3'b000} +: 8] = s;
      carry_d = c;
      k_d     = last ? '0 : k_q + KW'(1);
      if (last) begin
        cout_d      = c;
        ovf_d       = (in_a[7] == in_b[7]) && (s[7] != in_a[7]);
        state_d     = DONE;
        out_valid_d = 1'b1;
        in_ready_d  = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_byte_serial_adder.sv
// tb_byte_serial_adder: directed scenario tests for byte_serial_adder with NBYTES=4
module tb_byte_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_ovf;
  logic [7:0]  in_a, in_b;
  logic [31:0] out_sum;
  int tests = 0;
  int fails = 0;
  byte_serial_adder #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );
  always #5 clk = ~clk;
  task automatic drive_beat(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_cin   = ci;
  endtask
  task automatic send_word(input logic [31:0] a, input logic [31:0] b, input logic ci);
    for (int k = 0; k < 4; k++) drive_beat(1'b1, a[8*k +: 8], b[8*k +: 8], k == 0 ? ci : 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic handshake;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({in_ready, out_valid, out_sum, out_cout, out_ovf} !== 35'd0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, want all 0", in_ready, out_valid, out_sum, out_cout, out_ovf);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_release_ready: got %b want 0", in_ready); end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_to_accum: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask
  task automatic test_basic;
    logic [31:0] a = 32'h000000FF, b = 32'h00000001;
    for (int k = 0; k < 4; k++) drive_beat(1'b1, a[8*k +: 8], b[8*k +: 8], 1'b0);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 32'h00000100 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: got vld=%b sum=%h cout=%b ovf=%b want 1 00000100 0 0", out_valid, out_sum, out_cout, out_ovf);
    end
    handshake();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_handshake: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask
  task automatic test_carry_ovf;
    send_word(32'hFFFFFFFF, 32'h00000000, 1'b1);
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 32'h00000000 || out_cout !== 1'b1 || out_ovf !== 1'b0) begin
      fails++;
      $display("FAIL carry_in_wrap: got vld=%b sum=%h cout=%b ovf=%b want 1 00000000 1 0", out_valid, out_sum, out_cout, out_ovf);
    end
    handshake();
    send_word(32'h7FFFFFFF, 32'h00000001, 1'b0);
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 32'h80000000 || out_cout !== 1'b0 || out_ovf !== 1'b1) begin
      fails++;
      $display("FAIL signed_ovf: got vld=%b sum=%h cout=%b ovf=%b want 1 80000000 0 1", out_valid, out_sum, out_cout, out_ovf);
    end
    handshake();
  endtask
  task automatic test_backpressure;
    send_word(32'h12345678, 32'h11111111, 1'b0);
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_sum !== 32'h23456789 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold[%0d]: got vld=%b sum=%h rdy=%b want 1 23456789 0", i, out_valid, out_sum, in_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask
  task automatic test_gapped;
    logic [31:0] a = 32'h89ABCDEF, b = 32'h76543210;
    logic [6:0]  pat = 7'b1011001;
    int k = 0;
    for (int i = 0; i < 7; i++) begin
      if (pat[i]) begin
        drive_beat(1'b1, a[8*k +: 8], b[8*k +: 8], k == 0 ? 1'b1 : 1'b0);
        k++;
      end else drive_beat(1'b0, 8'hA5, 8'h5A, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 32'h00000000 || out_cout !== 1'b1 || out_ovf !== 1'b0) begin
      fails++;
      $display("FAIL gapped_result: got vld=%b sum=%h cout=%b ovf=%b want 1 00000000 1 0", out_valid, out_sum, out_cout, out_ovf);
    end
    handshake();
  endtask
  task automatic test_abort;
    drive_beat(1'b1, 8'hFF, 8'h01, 1'b0);
    drive_beat(1'b1, 8'hFF, 8'h00, 1'b0);
    drive_beat(1'b1, 8'hFF, 8'h00, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL clr_state: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    send_word(32'h00000001, 32'h00000001, 1'b0);
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 32'h00000002 || out_cout !== 1'b0) begin
      fails++;
      $display("FAIL clr_next_word: got vld=%b sum=%h cout=%b want 1 00000002 0", out_valid, out_sum, out_cout);
    end
    clr = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    clr = 1'b0; out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL clr_in_done: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    drive_beat(1'b1, 8'hFF, 8'h01, 1'b0);
    drive_beat(1'b1, 8'hFF, 8'h00, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: got rdy=%b vld=%b sum=%h want 0 0 00000000", in_ready, out_valid, out_sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_recover_ready: got %b want 1", in_ready); end
    send_word(32'h00000001, 32'h00000001, 1'b0);
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 32'h00000002 || out_cout !== 1'b0) begin
      fails++;
      $display("FAIL reset_next_word: got vld=%b sum=%h cout=%b want 1 00000002 0", out_valid, out_sum, out_cout);
    end
    handshake();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_carry_ovf();
    test_backpressure();
    test_gapped();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
